// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Iterative binary-to-BCD converter (shift-and-add-3, "double dabble").
// One input bit is consumed per clock; the result is registered and held
// until the next conversion is accepted.
//
// Handshake (both sides): a transfer happens on a rising edge where the
// producer's valid and the consumer's ready are both high. The input side is
// ready only in IDLE; the output side presents valid only in DONE. valid_in
// outside IDLE and ready_in outside DONE are ignored.
//
// Ports:
//   clk_in        system clock, rising edge
//   rst_n_in      asynchronous active-low reset
//   bin_in        unsigned binary value, sampled on the accept edge
//   valid_in      bin_in is valid
//   ready_out     converter can accept (IDLE)
//   bcd_out       result digits, digit 0 (ones) in bits [3:0]
//   digit_nz_out  per-digit significance mask for leading-zero blanking
//   ovf_out       input exceeded 10^DIGITS-1; bcd_out saturated to all nines
//   valid_out     result held and valid (DONE)
//   ready_in      downstream accepts the result
//   state_out     current FSM state (0 = IDLE, 1 = SHIFT, 2 = DONE)
//
// Timing: accept on edge k, BIN_W shift edges, one edge to register the
// result; valid_out is high after edge k+BIN_W+1.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_nz_out,
  output logic                  ovf_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [1:0]            state_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SH_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [SH_W-1:0]      sh_q;
  logic                 sticky_q;
  logic [BCD_W-1:0]     bcd_q;
  logic [DIGITS-1:0]    nz_q;
  logic                 ovf_q;

  logic                 last_iter;
  logic [BCD_W-1:0]     bcd_adj;
  logic [SH_W-1:0]      sh_adj;
  logic [SH_W-1:0]      sh_step;
  logic                 shout_bit;
  logic [BCD_W-1:0]     res_bcd;
  logic [DIGITS-1:0]    res_nz;

  // All BIN_W iterations done once the counter reaches BIN_W; that edge only
  // registers the result.
  assign last_iter = (cnt_q == CNT_W'(BIN_W));

  // One double-dabble iteration: add 3 to every digit >= 5, then shift left.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sh_q[BIN_W + 4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = sh_q[BIN_W + 4*i +: 4] + 4'd3;
      else
        bcd_adj[4*i +: 4] = sh_q[BIN_W + 4*i +: 4];
    end
  end

  assign sh_adj    = {bcd_adj, sh_q[BIN_W-1:0]};
  // The bit leaving the top digit means the running value no longer fits.
  assign shout_bit = bcd_adj[BCD_W-1];
  assign sh_step   = {sh_adj[SH_W-2:0], 1'b0};

  // Final result with saturation and significance mask.
  always_comb begin
    logic any_nz;
    any_nz  = 1'b0;
    res_nz  = '0;
    res_bcd = sticky_q ? {DIGITS{4'h9}} : sh_q[SH_W-1 -: BCD_W];
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz    = any_nz | (res_bcd[4*i +: 4] != 4'd0);
      res_nz[i] = any_nz;
    end
    // The ones digit is always shown, even for a zero result.
    res_nz[0] = 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (valid_in)  state_d = ST_SHIFT;
      ST_SHIFT: if (last_iter) state_d = ST_DONE;
      ST_DONE:  if (ready_in)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Datapath.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q    <= '0;
      sh_q     <= '0;
      sticky_q <= 1'b0;
      bcd_q    <= '0;
      nz_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_in) begin
            sh_q     <= {{BCD_W{1'b0}}, bin_in};
            cnt_q    <= '0;
            sticky_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (!last_iter) begin
            sh_q     <= sh_step;
            sticky_q <= sticky_q | shout_bit;
            cnt_q    <= cnt_q + CNT_W'(1);
          end else begin
            bcd_q <= res_bcd;
            nz_q  <= res_nz;
            ovf_q <= sticky_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_out    = (state_q == ST_IDLE);
  assign valid_out    = (state_q == ST_DONE);
  assign bcd_out      = bcd_q;
  assign digit_nz_out = nz_q;
  assign ovf_out      = ovf_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//
// Three converters: a (BIN_W=8, DIGITS=2), b (8,3), c (16,5). Drivers push the
// expected {ovf, nz, bcd} into a per-DUT queue when a conversion is issued;
// monitors pop and compare on every completed output handshake.
// Inputs are driven 1 time unit after the rising edge, monitors sample on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- DUT a: 8 bits, 2 digits ----------------
  logic [7:0]  a_bin;
  logic        a_vin, a_rin, a_rout, a_vout, a_ovf;
  logic [7:0]  a_bcd;
  logic [1:0]  a_nz, a_st;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_a (
    .clk_in(clk), .rst_n_in(rst_n), .bin_in(a_bin), .valid_in(a_vin),
    .ready_out(a_rout), .bcd_out(a_bcd), .digit_nz_out(a_nz), .ovf_out(a_ovf),
    .valid_out(a_vout), .ready_in(a_rin), .state_out(a_st)
  );

  // ---------------- DUT b: 8 bits, 3 digits ----------------
  logic [7:0]  b_bin;
  logic        b_vin, b_rin, b_rout, b_vout, b_ovf;
  logic [11:0] b_bcd;
  logic [2:0]  b_nz;
  logic [1:0]  b_st;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_b (
    .clk_in(clk), .rst_n_in(rst_n), .bin_in(b_bin), .valid_in(b_vin),
    .ready_out(b_rout), .bcd_out(b_bcd), .digit_nz_out(b_nz), .ovf_out(b_ovf),
    .valid_out(b_vout), .ready_in(b_rin), .state_out(b_st)
  );

  // ---------------- DUT c: 16 bits, 5 digits ----------------
  logic [15:0] c_bin;
  logic        c_vin, c_rin, c_rout, c_vout, c_ovf;
  logic [19:0] c_bcd;
  logic [4:0]  c_nz;
  logic [1:0]  c_st;

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_c (
    .clk_in(clk), .rst_n_in(rst_n), .bin_in(c_bin), .valid_in(c_vin),
    .ready_out(c_rout), .bcd_out(c_bcd), .digit_nz_out(c_nz), .ovf_out(c_ovf),
    .valid_out(c_vout), .ready_in(c_rin), .state_out(c_st)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] a_q[$];
  logic [63:0] b_q[$];
  logic [63:0] c_q[$];

  function automatic logic [63:0] pk(input logic ovf, input logic [9:0] nz,
                                     input logic [39:0] bcd);
    return {13'd0, ovf, nz, bcd};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input string name, inout logic [63:0] q[$],
                           input logic [63:0] act);
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got unexpected result %h expected none", name, act);
    end else begin
      check(name, act, q.pop_front());
    end
  endtask

  always @(negedge clk)
    if (rst_n && a_vout && a_rin)
      pop_check("a_result", a_q, pk(a_ovf, 10'(a_nz), 40'(a_bcd)));

  always @(negedge clk)
    if (rst_n && b_vout && b_rin)
      pop_check("b_result", b_q, pk(b_ovf, 10'(b_nz), 40'(b_bcd)));

  always @(negedge clk)
    if (rst_n && c_vout && c_rin)
      pop_check("c_result", c_q, pk(c_ovf, 10'(c_nz), 40'(c_bcd)));

  // ---------------- drivers ----------------
  // Issue one conversion on DUT a (must be in IDLE) and wait for valid_out.
  // Returns 1 time unit after the edge on which valid_out first appears.
  task automatic a_convert(input logic [7:0] v, input logic [63:0] exp);
    int edges;
    check("a_ready_before_accept", 64'(a_rout), 64'd1);
    a_bin = v;
    a_vin = 1'b1;
    a_q.push_back(exp);
    @(posedge clk); #1;
    a_vin = 1'b0;
    a_bin = 8'($urandom_range(0, 255));  // must not disturb the conversion
    edges = 1;
    while (!a_vout && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    check("a_latency_edges", 64'(edges), 64'd10);
  endtask

  task automatic a_release;
    @(posedge clk); #1;
    check("a_back_to_idle", 64'({a_rout, a_vout}), 64'b10);
  endtask

  task automatic b_convert(input logic [7:0] v, input logic [63:0] exp);
    int edges;
    b_bin = v;
    b_vin = 1'b1;
    b_q.push_back(exp);
    @(posedge clk); #1;
    b_vin = 1'b0;
    edges = 1;
    while (!b_vout && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    check("b_latency_edges", 64'(edges), 64'd10);
    @(posedge clk); #1;
  endtask

  task automatic c_convert(input logic [15:0] v, input logic [63:0] exp);
    int edges;
    c_bin = v;
    c_vin = 1'b1;
    c_q.push_back(exp);
    @(posedge clk); #1;
    c_vin = 1'b0;
    c_bin = 16'($urandom_range(0, 65535));
    edges = 1;
    while (!c_vout && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    check("c_latency_edges", 64'(edges), 64'd18);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    a_bin = '0; a_vin = 1'b0; a_rin = 1'b1;
    b_bin = '0; b_vin = 1'b0; b_rin = 1'b1;
    c_bin = '0; c_vin = 1'b0; c_rin = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("a_reset_outputs", pk(a_ovf, 10'(a_nz), 40'(a_bcd)), 64'd0);
    check("a_reset_hs", 64'({a_rout, a_vout, a_st}), 64'b1000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic values, leading-zero mask, zero.
    a_convert(8'd81, pk(1'b0, 10'b11, 40'h81)); a_release();
    a_convert(8'd7,  pk(1'b0, 10'b01, 40'h07)); a_release();
    a_convert(8'd0,  pk(1'b0, 10'b01, 40'h00)); a_release();
    a_convert(8'd10, pk(1'b0, 10'b11, 40'h10)); a_release();
    // Range boundary and overflow saturation.
    a_convert(8'd99,  pk(1'b0, 10'b11, 40'h99)); a_release();
    a_convert(8'd100, pk(1'b1, 10'b11, 40'h99)); a_release();
    a_convert(8'd255, pk(1'b1, 10'b11, 40'h99)); a_release();
    // Overflow flag must clear for the next in-range value.
    a_convert(8'd5,   pk(1'b0, 10'b01, 40'h05)); a_release();

    // Backpressure: hold ready_in low in DONE, poke valid_in meanwhile.
    a_rin = 1'b0;
    a_convert(8'd56, pk(1'b0, 10'b11, 40'h56));
    for (int i = 0; i < 5; i++) begin
      check("a_bp_hold", {51'd0, a_vout, a_rout, a_st, a_bcd}, {51'd0, 1'b1, 1'b0, 2'd2, 8'h56});
      a_vin = 1'b1;
      a_bin = 8'd12;
      @(posedge clk); #1;
    end
    a_vin = 1'b0;
    a_rin = 1'b1;
    @(posedge clk); #1;
    check("a_bp_released", 64'({a_rout, a_vout, a_st}), 64'b1000);
    check("a_bp_held_after_idle", 64'(a_bcd), 64'h56);
    a_bin = 8'd33;
    a_vin = 1'b1;
    a_q.push_back(pk(1'b0, 10'b11, 40'h33));
    @(posedge clk); #1;
    a_vin = 1'b0;
    check("a_accept_after_bp", 64'({a_rout, a_st}), 64'b001);
    begin
      int edges;
      edges = 1;
      while (!a_vout && edges < 100) begin
        @(posedge clk); #1;
        edges++;
      end
      check("a_latency_edges", 64'(edges), 64'd10);
    end
    a_release();

    // Wider configurations.
    b_convert(8'd255, pk(1'b0, 10'b111, 40'h255));
    b_convert(8'd5,   pk(1'b0, 10'b001, 40'h005));
    b_convert(8'd100, pk(1'b0, 10'b111, 40'h100));
    c_convert(16'd65535, pk(1'b0, 10'b11111, 40'h65535));
    c_convert(16'd1000,  pk(1'b0, 10'b01111, 40'h01000));

    // Reset mid-SHIFT: partial result discarded, held result cleared.
    check("a_ready_before_abort", 64'(a_rout), 64'd1);
    a_bin = 8'd200;
    a_vin = 1'b1;
    @(posedge clk); #1;
    a_vin = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("a_abort_outputs", pk(a_ovf, 10'(a_nz), 40'(a_bcd)), 64'd0);
    check("a_abort_hs", 64'({a_rout, a_vout, a_st}), 64'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    a_convert(8'd42, pk(1'b0, 10'b11, 40'h42)); a_release();

    // Drain.
    for (int i = 0; i < 50; i++) begin
      if (a_q.size() == 0 && b_q.size() == 0 && c_q.size() == 0) break;
      @(posedge clk);
    end
    check("queues_drained", 64'(a_q.size() + b_q.size() + c_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
